// File: rtl/u_tx_pkg.sv
// Shared UART definitions: frame state encoding, default frame geometry and the parity helper.
package u_tx_pkg;

    localparam int DEF_WIDTH        = 8;
    localparam int DEF_NO_OF_SAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Zero padding above the real data width does not change the XOR reduction.
    function automatic logic parity_bit(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/u_tx.sv
// UART transmitter: one-word holding register feeding a start/data/parity/stop serialiser,
// paced by the shared oversample tick so frames can run back-to-back.
//
// state  | meaning
// IDLE   | line high, waiting for a tick with the holding register full
// START  | driving the start bit (low)
// DATA   | driving data bits LSB first, shifter[0] is on the line
// PARITY | driving the parity bit computed at load time
// STOP   | driving stop bit(s) high; reloads straight into START if a word is queued
module u_tx
    import u_tx_pkg::*;
#(
    parameter int width        = DEF_WIDTH,
    parameter int no_of_sample = DEF_NO_OF_SAMPLE,
    parameter int parity_en    = 0,
    parameter int parity_odd   = 0,
    parameter int stop_bits    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             baud_en_tx,
    input  logic             tx_valid,
    input  logic [width-1:0] tx_data,
    output logic             tx_ready,
    output logic             tx_out,
    output logic             tx_active,
    output logic             tx_done
);

    localparam int SC_W = $clog2(no_of_sample);
    localparam int BI_W = $clog2(width);
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(no_of_sample - 1);
    localparam logic [BI_W-1:0] BI_LAST   = BI_W'(width - 1);
    localparam logic [BI_W-1:0] STOP_LAST = BI_W'(stop_bits - 1);

    uart_state_t      state, state_n;
    logic [SC_W-1:0]  sample_count, sample_count_n;
    logic [BI_W-1:0]  bit_index, bit_index_n;
    logic [width-1:0] shifter, shifter_n;
    logic [width-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic             par, par_n;
    logic             tx_out_n, tx_active_n, tx_done_n;

    assign tx_ready = ~hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sample_count <= '0;
            bit_index    <= '0;
            shifter      <= '0;
            hold         <= '0;
            hold_full    <= 1'b0;
            par          <= 1'b0;
            tx_out       <= 1'b1;
            tx_active    <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            state        <= state_n;
            sample_count <= sample_count_n;
            bit_index    <= bit_index_n;
            shifter      <= shifter_n;
            hold         <= hold_n;
            hold_full    <= hold_full_n;
            par          <= par_n;
            tx_out       <= tx_out_n;
            tx_active    <= tx_active_n;
            tx_done      <= tx_done_n;
        end
    end

    always_comb begin
        state_n        = state;
        sample_count_n = sample_count;
        bit_index_n    = bit_index;
        shifter_n      = shifter;
        hold_n         = hold;
        hold_full_n    = hold_full;
        par_n          = par;
        tx_out_n       = tx_out;
        tx_active_n    = tx_active;
        tx_done_n      = 1'b0;

        // Accept and load are mutually exclusive: accept needs hold empty, load needs it full.
        if (tx_valid && !hold_full) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
        end

        if (baud_en_tx) begin
            if (state == IDLE) begin
                tx_out_n = 1'b1;
                if (hold_full) begin
                    shifter_n      = hold;
                    hold_full_n    = 1'b0;
                    par_n          = parity_bit(16'(hold), parity_odd != 0);
                    tx_out_n       = 1'b0;
                    tx_active_n    = 1'b1;
                    sample_count_n = '0;
                    state_n        = START;
                end
            end else if (sample_count != SC_LAST) begin
                sample_count_n = sample_count + SC_W'(1);
            end else begin
                sample_count_n = '0;
                case (state)
                    START: begin
                        tx_out_n    = shifter[0];
                        bit_index_n = '0;
                        state_n     = DATA;
                    end
                    DATA: begin
                        if (bit_index == BI_LAST) begin
                            bit_index_n = '0;
                            if (parity_en != 0) begin
                                tx_out_n = par;
                                state_n  = PARITY;
                            end else begin
                                tx_out_n = 1'b1;
                                state_n  = STOP;
                            end
                        end else begin
                            bit_index_n = bit_index + BI_W'(1);
                            shifter_n   = shifter >> 1;
                            tx_out_n    = shifter[1];
                        end
                    end
                    PARITY: begin
                        bit_index_n = '0;
                        tx_out_n    = 1'b1;
                        state_n     = STOP;
                    end
                    STOP: begin
                        if (bit_index == STOP_LAST) begin
                            tx_done_n   = 1'b1;
                            bit_index_n = '0;
                            if (hold_full) begin
                                shifter_n   = hold;
                                hold_full_n = 1'b0;
                                par_n       = parity_bit(16'(hold), parity_odd != 0);
                                tx_out_n    = 1'b0;
                                state_n     = START;
                            end else begin
                                tx_out_n    = 1'b1;
                                tx_active_n = 1'b0;
                                state_n     = IDLE;
                            end
                        end else begin
                            bit_index_n = bit_index + BI_W'(1);
                        end
                    end
                    default: begin
                        tx_out_n    = 1'b1;
                        tx_active_n = 1'b0;
                        state_n     = IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_u_tx.sv
// Bench for u_tx: four instances (plain, even parity, odd parity, two stop bits) share one tick;
// a monitor decodes each frame from the line and checks it against a queue of expected words.
module tb_u_tx;

    localparam logic [3:0] PE  = 4'b0110;
    localparam logic [3:0] PO  = 4'b0100;
    localparam logic [3:0] SB2 = 4'b1000;

    typedef struct {
        int         chan;
        logic [7:0] data;
        logic       par;
        int         div;
        bit         b2b;
        bit         abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud = 1'b0;
    logic [3:0] valid = '0;
    logic [7:0] data_ch [4];
    logic [3:0] ready, out, active, done;

    int   div = 1;
    int   bcnt = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_busy = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        bcnt = bcnt + 1;
        if (bcnt >= div) bcnt = 0;
        baud = (bcnt == 0);
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        u_tx #(
            .width(8), .no_of_sample(16),
            .parity_en(PE[g] ? 1 : 0), .parity_odd(PO[g] ? 1 : 0), .stop_bits(SB2[g] ? 2 : 1)
        ) dut (
            .clk(clk), .rst(rst), .baud_en_tx(baud),
            .tx_valid(valid[g]), .tx_data(data_ch[g]),
            .tx_ready(ready[g]), .tx_out(out[g]),
            .tx_active(active[g]), .tx_done(done[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input int ch, input logic [7:0] d, input bit b2b, input bit ab);
        exp_t e;
        int   w;
        e.chan = ch; e.data = d; e.div = div; e.b2b = b2b; e.abort = ab;
        e.par  = PO[ch] ? ~^d : ^d;
        exp_q.push_back(e);
        @(negedge clk);
        data_ch[ch] = d;
        valid[ch]   = 1'b1;
        w = 0;
        while (!ready[ch] && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) check("ready_timeout", 0, 1);
        @(negedge clk);
        valid[ch] = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || mon_busy) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) check("idle_timeout", 0, 1);
    endtask

    initial begin : monitor
        exp_t        e;
        int          c, len, gap, cnt, flen, nb, pe;
        logic [11:0] line;
        bit          act_ok, stop_ok;
        forever begin
            if (exp_q.size() == 0 || rst) begin
                @(negedge clk);
                continue;
            end
            e = exp_q.pop_front();
            mon_busy = 1'b1;
            c    = e.chan;
            len  = 16 * e.div;
            pe   = PE[c] ? 1 : 0;
            nb   = 1 + 8 + pe + (SB2[c] ? 2 : 1);
            flen = nb * len;
            gap  = 0;
            while (out[c] != 1'b0 && gap < 3000) begin
                @(negedge clk);
                gap++;
            end
            if (gap >= 3000) begin
                check("start_timeout", 0, 1);
            end else if (e.abort) begin
                cnt = 0;
                while (!rst && cnt < 3000) begin
                    @(negedge clk);
                    cnt++;
                end
                if (cnt >= 3000) check("abort_timeout", 0, 1);
            end else begin
                if (e.b2b) check("b2b_gap", gap, 0);
                line   = '1;
                act_ok = 1'b1;
                cnt    = 0;
                while (cnt < flen + 2 * len) begin
                    @(negedge clk);
                    cnt++;
                    if (cnt % len == len / 2 && cnt / len < 12) begin
                        line[cnt / len] = out[c];
                        if (!active[c]) act_ok = 1'b0;
                    end
                    if (done[c]) break;
                end
                check("frame_len", cnt, flen);
                check("start_bit", line[0], 0);
                check("data_bits", line[8:1], e.data);
                if (pe != 0) check("parity_bit", line[9], e.par);
                stop_ok = 1'b1;
                for (int k = 9 + pe; k < nb; k++) if (!line[k]) stop_ok = 1'b0;
                check("stop_bits", stop_ok, 1);
                check("active_in_frame", act_ok, 1);
                check("active_after_done", active[c], !out[c]);
            end
            mon_busy = 1'b0;
        end
    end

    initial begin : main
        int w;
        for (int i = 0; i < 4; i++) data_ch[i] = '0;
        @(negedge clk);
        check("rst_out", out, 4'hF);
        check("rst_ready", ready, 4'hF);
        check("rst_active", active, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        send(0, 8'hA5, 0, 0);
        wait_idle();
        send(1, 8'h07, 0, 0);
        wait_idle();
        send(2, 8'h07, 0, 0);
        wait_idle();

        send(0, 8'h55, 0, 0);
        send(0, 8'hAA, 1, 0);
        check("ready_drop", ready[0], 0);
        repeat (100) @(negedge clk);
        check("ready_held", ready[0], 0);
        repeat (100) @(negedge clk);
        check("ready_rise", ready[0], 1);
        wait_idle();

        send(0, 8'h3C, 0, 1);
        w = 0;
        while (out[0] != 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        repeat (72) @(negedge clk);
        check("pre_abort_active", active[0], 1);
        rst = 1'b1;
        #1;
        check("abort_out", out, 4'hF);
        check("abort_active", active, 0);
        check("abort_ready", ready, 4'hF);
        check("abort_done", done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_idle();
        send(0, 8'h3C, 0, 0);
        wait_idle();

        div = 4;
        send(3, 8'h81, 0, 0);
        wait_idle();
        div = 1;

        for (int i = 0; i < 64; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            send(0, 8'($urandom), 0, 0);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
